// File: rtl/gb_alu_seq_if.sv
// gb_alu_seq_if: request/response handshake bundle for gb_alu_seq.
// The master modport belongs to the requester, and the slave modport belongs to the ALU sequencer.
interface gb_alu_seq_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic        rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/gb_alu_seq.sv
// gb_alu_seq: a sequencer that runs 8-bit ADD/ADC/SUB/SBC operations, and an optional 16-bit ADD,
// through an external shared 8-bit adder. It keeps a {Z,N,H,C} flag register between operations.
// The 16-bit ADD (opcode 4) is built only when the macro GB_ALU_SEQ_ADD16_EN is defined.
// When the macro is not defined, opcode 4 is treated as an illegal opcode.
module gb_alu_seq #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gb_alu_seq_if.slave           bus,
  output logic [DATA_WIDTH-1:0] alu_a,
  output logic [DATA_WIDTH-1:0] alu_b,
  output logic                  alu_cin,
  output logic                  alu_sub,
  input  logic [DATA_WIDTH-1:0] alu_sum,
  input  logic                  alu_cout,
  input  logic                  alu_hcout
);

  localparam logic [2:0] OP_ADD8  = 3'd0;
  localparam logic [2:0] OP_ADC8  = 3'd1;
  localparam logic [2:0] OP_SUB8  = 3'd2;
  localparam logic [2:0] OP_SBC8  = 3'd3;
  localparam logic [2:0] OP_ADD16 = 3'd4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 0;

`ifdef GB_ALU_SEQ_ADD16_EN
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC_LO = 2'd1, RESP = 2'd2, EXEC_HI = 2'd3} state_e;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, EXEC_LO = 2'd1, RESP = 2'd2} state_e;
`endif

  state_e      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] a_q, b_q;
  logic [15:0] result_q;
  logic [3:0]  flags_q;
  logic        err_q;
  logic        op_legal;

`ifdef GB_ALU_SEQ_ADD16_EN
  logic        lo_carry_q;  // carry out of the low byte, fed into the high byte
  assign op_legal = (bus.req_op <= OP_ADD16);
`else
  // The high operand bytes have no consumer when the 16-bit path is not built.
  logic        unused_hi;
  assign unused_hi = ^{a_q[15:8], b_q[15:8]};
  assign op_legal  = (bus.req_op <= OP_SBC8);
`endif

  assign bus.req_ready  = (state_q == IDLE);
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_result = result_q;
  assign bus.rsp_flags  = flags_q;
  assign bus.rsp_err    = err_q;

  // State register: reset aborts any operation in flight and returns to IDLE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic. An illegal opcode skips execution and goes straight to the response.
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = op_legal ? EXEC_LO : RESP;
`ifdef GB_ALU_SEQ_ADD16_EN
      EXEC_LO: state_d = (op_q == OP_ADD16) ? EXEC_HI : RESP;
      EXEC_HI: state_d = RESP;
`else
      EXEC_LO: state_d = RESP;
`endif
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Adder drive: operands come only from registered copies, and are zero outside the execution states.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    alu_sub = 1'b0;
    case (state_q)
      EXEC_LO: begin
        alu_a   = a_q[DATA_WIDTH-1:0];
        alu_b   = b_q[DATA_WIDTH-1:0];
        alu_sub = (op_q == OP_SUB8) || (op_q == OP_SBC8);
        alu_cin = ((op_q == OP_ADC8) || (op_q == OP_SBC8)) && flags_q[FLAG_C];
      end
`ifdef GB_ALU_SEQ_ADD16_EN
      EXEC_HI: begin
        alu_a   = a_q[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_b   = b_q[2*DATA_WIDTH-1:DATA_WIDTH];
        alu_cin = lo_carry_q;
      end
`endif
      default: ;
    endcase
  end

  // Datapath: capture the request on accept, and capture adder results on each execution edge.
  // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      result_q   <= '0;
      flags_q    <= '0;
      err_q      <= 1'b0;
`ifdef GB_ALU_SEQ_ADD16_EN
      lo_carry_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            op_q     <= bus.req_op;
            a_q      <= bus.req_a;
            b_q      <= bus.req_b;
            result_q <= '0;
            err_q    <= !op_legal;
          end
        end
        EXEC_LO: begin
`ifdef GB_ALU_SEQ_ADD16_EN
          if (op_q == OP_ADD16) begin
            result_q[DATA_WIDTH-1:0] <= alu_sum;
            lo_carry_q               <= alu_cout;
          end else
`endif
          begin
            result_q <= {{(16-DATA_WIDTH){1'b0}}, alu_sum};
            flags_q  <= {(alu_sum == '0), alu_sub, alu_hcout, alu_cout};
          end
        end
`ifdef GB_ALU_SEQ_ADD16_EN
        EXEC_HI: begin
          // The 16-bit add keeps the previous Z flag and reports half carry and carry from the high byte.
          result_q[2*DATA_WIDTH-1:DATA_WIDTH] <= alu_sum;
          flags_q <= {flags_q[FLAG_Z], 1'b0, alu_hcout, alu_cout};
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_alu_seq.sv
// tb_gb_alu_seq: a table-driven bench for gb_alu_seq, with a scoreboard of expected responses.
// It also models the shared 8-bit adder. It covers both builds of GB_ALU_SEQ_ADD16_EN.
module tb_gb_alu_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] alu_a, alu_b, alu_sum;
  logic       alu_cin, alu_sub, alu_cout, alu_hcout;
  logic [8:0] full;
  logic [4:0] half;

  gb_alu_seq_if bus ();

  gb_alu_seq #(.DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_cin   (alu_cin),
    .alu_sub   (alu_sub),
    .alu_sum   (alu_sum),
    .alu_cout  (alu_cout),
    .alu_hcout (alu_hcout)
  );

  always #125 clk = ~clk;

  // Shared adder model. When subtracting, cout and hcout are the borrows out of bit 7 and bit 3.
  always_comb begin
    if (alu_sub) begin
      full = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
      half = {1'b0, alu_a[3:0]} - {1'b0, alu_b[3:0]} - {4'd0, alu_cin};
    end else begin
      full = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
      half = {1'b0, alu_a[3:0]} + {1'b0, alu_b[3:0]} + {4'd0, alu_cin};
    end
  end
  assign alu_sum   = full[7:0];
  assign alu_cout  = full[8];
  assign alu_hcout = half[4];

`ifdef GB_ALU_SEQ_ADD16_EN
  localparam bit ADD16_ON = 1'b1;
`else
  localparam bit ADD16_ON = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;
  } vec_t;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  flags;
    logic        err;
    int          lat;
  } exp_t;

  vec_t       vecs[$];
  exp_t       sb_q[$];
  logic [3:0] model_flags;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic bit op_legal(input logic [2:0] op);
    return (op < 3'd4) || (ADD16_ON && (op == 3'd4));
  endfunction

  // Issue one operation and wait a bounded time for its response.
  // Compare the response against the scoreboard, optionally stall the response, then complete the handshake.
  task automatic run_vec(input vec_t v, input int stall);
    exp_t       e;
    int         n;
    logic [8:0] lo_sum;
    logic       e_cin, e_sub;
    e.result = v.result;
    e.flags  = v.flags;
    e.err    = v.err;
    e.lat    = !op_legal(v.op) ? 0 : ((v.op == 3'd4) ? 2 : 1);
    e_cin    = ((v.op == 3'd1) || (v.op == 3'd3)) ? model_flags[0] : 1'b0;
    e_sub    = (v.op == 3'd2) || (v.op == 3'd3);
    lo_sum   = {1'b0, v.a[7:0]} + {1'b0, v.b[7:0]};

    check("req_ready_idle", bus.req_ready, 1);
    bus.req_op    = v.op;
    bus.req_a     = v.a;
    bus.req_b     = v.b;
    bus.req_valid = 1'b1;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    // After the request is accepted, the inputs are scrambled; this must not disturb the operation in flight.
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd7;
    bus.req_a     = ~v.a;
    bus.req_b     = ~v.b;
    check("req_ready_busy", bus.req_ready, 0);

    n = 0;
    while (!bus.rsp_valid && n < 8) begin
      if (n == 0) begin
        check("alu_a_lo",   alu_a,   v.a[7:0]);
        check("alu_b_lo",   alu_b,   v.b[7:0]);
        check("alu_cin_lo", alu_cin, e_cin);
        check("alu_sub_lo", alu_sub, e_sub);
      end else if (n == 1) begin
        check("alu_a_hi",   alu_a,   v.a[15:8]);
        check("alu_b_hi",   alu_b,   v.b[15:8]);
        check("alu_cin_hi", alu_cin, lo_sum[8]);
        check("alu_sub_hi", alu_sub, 0);
      end
      @(negedge clk);
      n++;
    end

    e = sb_q.pop_front();
    check("latency",    n,              e.lat);
    check("rsp_result", bus.rsp_result, e.result);
    check("rsp_flags",  bus.rsp_flags,  e.flags);
    check("rsp_err",    bus.rsp_err,    e.err);
    check("alu_zero_in_resp", {alu_a, alu_b, alu_cin, alu_sub}, 0);

    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid",  bus.rsp_valid,  1);
      check("stall_ready",  bus.req_ready,  0);
      check("stall_result", bus.rsp_result, e.result);
      check("stall_flags",  bus.rsp_flags,  e.flags);
      check("stall_err",    bus.rsp_err,    e.err);
    end

    bus.rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    check("rsp_valid_after_hs", bus.rsp_valid, 0);
    model_flags = v.flags;
  endtask

  // Safety net: the bench never runs away even if a bounded loop is broken.
  initial begin
    #(250 * 20000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_a     = 16'h0;
    bus.req_b     = 16'h0;
    bus.rsp_ready = 1'b0;
    model_flags   = 4'b0000;

    // Stimulus table {op, a, b, result, flags {Z,N,H,C}, err}. Each row's flags feed the next row.
    vecs.push_back('{3'd0, 16'h000F, 16'h0001, 16'h0010, 4'b0010, 1'b0});
    vecs.push_back('{3'd2, 16'h0010, 16'h0020, 16'h00F0, 4'b0101, 1'b0});
    vecs.push_back('{3'd3, 16'h0005, 16'h0004, 16'h0000, 4'b1100, 1'b0});
    vecs.push_back('{3'd2, 16'h0010, 16'h0020, 16'h00F0, 4'b0101, 1'b0});
    vecs.push_back('{3'd1, 16'h00FF, 16'h0000, 16'h0000, 4'b1011, 1'b0});
`ifdef GB_ALU_SEQ_ADD16_EN
    vecs.push_back('{3'd4, 16'h0FFF, 16'h0001, 16'h1000, 4'b1010, 1'b0});
    vecs.push_back('{3'd7, 16'h1234, 16'h4321, 16'h0000, 4'b1010, 1'b1});
`else
    vecs.push_back('{3'd4, 16'h0FFF, 16'h0001, 16'h0000, 4'b1011, 1'b1});
    vecs.push_back('{3'd7, 16'h1234, 16'h4321, 16'h0000, 4'b1011, 1'b1});
`endif
    vecs.push_back('{3'd0, 16'h0080, 16'h0080, 16'h0000, 4'b1001, 1'b0});
    vecs.push_back('{3'd1, 16'h0001, 16'h0001, 16'h0003, 4'b0000, 1'b0});
    vecs.push_back('{3'd3, 16'h0000, 16'h0000, 16'h0000, 4'b1100, 1'b0});
    vecs.push_back('{3'd2, 16'h0000, 16'h0001, 16'h00FF, 4'b0111, 1'b0});
`ifdef GB_ALU_SEQ_ADD16_EN
    vecs.push_back('{3'd4, 16'h12F0, 16'h3420, 16'h4710, 4'b0000, 1'b0});
    vecs.push_back('{3'd5, 16'h1234, 16'h5678, 16'h0000, 4'b0000, 1'b1});
`else
    vecs.push_back('{3'd4, 16'h12F0, 16'h3420, 16'h0000, 4'b0111, 1'b1});
    vecs.push_back('{3'd5, 16'h1234, 16'h5678, 16'h0000, 4'b0111, 1'b1});
`endif
    vecs.push_back('{3'd0, 16'hAB3C, 16'h1104, 16'h0040, 4'b0010, 1'b0});
    vecs.push_back('{3'd2, 16'h0042, 16'h0042, 16'h0000, 4'b1100, 1'b0});
    vecs.push_back('{3'd6, 16'h00FF, 16'h00FF, 16'h0000, 4'b1100, 1'b1});

    // Reset state, checked while reset is held.
    @(negedge clk);
    check("rst_rsp_valid", bus.rsp_valid,  0);
    check("rst_result",    bus.rsp_result, 0);
    check("rst_flags",     bus.rsp_flags,  0);
    check("rst_err",       bus.rsp_err,    0);
    check("rst_alu",       {alu_a, alu_b, alu_cin, alu_sub}, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_rst", bus.req_ready, 1);

    foreach (vecs[i]) run_vec(vecs[i], 0);

    // Hold the response for 5 cycles, then issue a request right after the handshake.
    run_vec('{3'd0, 16'h0000, 16'h0000, 16'h0000, 4'b1000, 1'b0}, 5);
    run_vec('{3'd0, 16'h00FF, 16'h0002, 16'h0001, 4'b0011, 1'b0}, 0);

    // Assert reset while EXEC_LO is running. The operation is dropped and the outputs return to their reset values at once.
    bus.req_op    = 3'd0;
    bus.req_a     = 16'h000F;
    bus.req_b     = 16'h0001;
    bus.req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    check("abort_alu_a_exec", alu_a, 8'h0F);
    rst = 1'b0;
    #1;
    check("abort_rsp_valid", bus.rsp_valid,  0);
    check("abort_result",    bus.rsp_result, 0);
    check("abort_flags",     bus.rsp_flags,  0);
    check("abort_err",       bus.rsp_err,    0);
    check("abort_alu",       {alu_a, alu_b, alu_cin, alu_sub}, 0);
    check("abort_ready",     bus.req_ready,  1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_abort", bus.req_ready, 1);
    seen = bus.rsp_valid;
    repeat (5) begin
      @(negedge clk);
      if (bus.rsp_valid) seen = 1'b1;
    end
    check("no_rsp_after_abort", seen, 0);
    model_flags = 4'b0000;

    run_vec('{3'd0, 16'h000F, 16'h0001, 16'h0010, 4'b0010, 1'b0}, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
